ucca_cfg_ctrl: RTL and testbench

- Boot-time configuration controller for the UCCA region monitors.
- On cfg_start it fetches a region table from the META area through a request/ack read port, then validates it: count range, alignment, min<=max, pairwise non-overlap.
- Drives per-region ucc_min/ucc_max, then locks them until system_reset.
- cfg_fault is sticky and is ORed into master_reset next to the CR integrity and region resets.

---
 rtl/ucca_cfg_pkg.sv | 33 +++
 rtl/ucca_cfg_ctrl_if.sv | 10 +
 rtl/ucca_cfg_overlap_chk.sv | 10 +
 rtl/ucca_cfg_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_ucca_cfg_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucca_cfg_pkg.sv
// Shared constants and types for the UCCA boot-time configuration controller.
package ucca_cfg_pkg;

  localparam int unsigned N_REGIONS_MAX = 8;

  localparam logic [15:0] META_BASE = 16'h0140;
  localparam logic [15:0] CNT_OFS   = 16'd0;
  localparam logic [15:0] MIN_OFS   = 16'd2;
  localparam logic [15:0] MAX_OFS   = 16'd4;
  localparam logic [15:0] STRIDE    = 16'd4;

  typedef logic [2:0] state_t;
  localparam state_t StIdle   = 3'd0;
  localparam state_t StRdCnt  = 3'd1;
  localparam state_t StRdMin  = 3'd2;
  localparam state_t StRdMax  = 3'd3;
  localparam state_t StChk    = 3'd4;
  localparam state_t StLocked = 3'd5;
  localparam state_t StFault  = 3'd6;

  typedef logic [2:0] fault_code_t;
  localparam fault_code_t FaultNone    = 3'd0;
  localparam fault_code_t FaultCount   = 3'd1;
  localparam fault_code_t FaultAlign   = 3'd2;
  localparam fault_code_t FaultBounds  = 3'd3;
  localparam fault_code_t FaultOverlap = 3'd4;
  localparam fault_code_t FaultTimeout = 3'd5;

  function automatic logic [15:0] tbl_addr(logic [15:0] base, logic [15:0] ofs, logic [2:0] idx);
    return base + ofs + STRIDE * {13'd0, idx};
  endfunction

endpackage

// File: rtl/ucca_cfg_ctrl_if.sv
// Request/acknowledge read port used to fetch the region table from META.
interface ucca_cfg_ctrl_if;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_ack, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_ack, output rd_data);
endinterface

// File: rtl/ucca_cfg_overlap_chk.sv
// Closed-interval overlap test; shared endpoints count as overlapping.
module ucca_cfg_overlap_chk (
  input  logic [15:0] min_a,
  input  logic [15:0] max_a,
  input  logic [15:0] min_b,
  input  logic [15:0] max_b,
  output logic        overlap
);
  assign overlap = (min_a <= max_b) && (min_b <= max_a);
endmodule

// File: rtl/ucca_cfg_ctrl.sv
// Fetches and validates the UCCA region table, then drives and locks the region bounds.
module ucca_cfg_ctrl #(
  parameter int unsigned N_REGIONS = 8,
  parameter logic [15:0] META_BASE = ucca_cfg_pkg::META_BASE,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                     clk,
  input  logic                     system_reset,
  input  logic                     cfg_start,
  ucca_cfg_ctrl_if.master          rd,
  output logic [16*N_REGIONS-1:0]  ucc_min_flat,
  output logic [16*N_REGIONS-1:0]  ucc_max_flat,
  output logic [N_REGIONS-1:0]     region_en,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_fault,
  output logic [2:0]               fault_code,
  output logic [2:0]               fault_idx
);
  import ucca_cfg_pkg::*;

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic                    rd_req_q, rd_req_d;
  logic [15:0]             rd_addr_q, rd_addr_d;
  logic [WaitW-1:0]        wait_q, wait_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [2:0]              idx_q, idx_d;
  logic [2:0]              ci_q, ci_d;
  logic [2:0]              cj_q, cj_d;
  logic [15:0]             min_sh_q [N_REGIONS_MAX];
  logic [15:0]             min_sh_d [N_REGIONS_MAX];
  logic [15:0]             max_sh_q [N_REGIONS_MAX];
  logic [15:0]             max_sh_d [N_REGIONS_MAX];
  logic [16*N_REGIONS-1:0] min_flat_q, min_flat_d;
  logic [16*N_REGIONS-1:0] max_flat_q, max_flat_d;
  logic [N_REGIONS-1:0]    en_q, en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fault_q, fault_d;
  fault_code_t             code_q, code_d;
  logic [2:0]              fidx_q, fidx_d;

  logic                    ack;
  logic                    pair_overlap;
  logic                    go_fault;
  logic                    go_lock;
  fault_code_t             new_code;
  logic [2:0]              new_idx;

  ucca_cfg_overlap_chk u_overlap (
    .min_a   (min_sh_q[ci_q]),
    .max_a   (max_sh_q[ci_q]),
    .min_b   (min_sh_q[cj_q]),
    .max_b   (max_sh_q[cj_q]),
    .overlap (pair_overlap)
  );

  // An acknowledge only counts while a request is outstanding.
  assign ack = rd.rd_ack && rd_req_q;

  always_comb begin
    state_d    = state_q;
    rd_req_d   = rd_req_q;
    rd_addr_d  = rd_addr_q;
    wait_d     = wait_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ci_d       = ci_q;
    cj_d       = cj_q;
    min_sh_d   = min_sh_q;
    max_sh_d   = max_sh_q;
    min_flat_d = min_flat_q;
    max_flat_d = max_flat_q;
    en_d       = en_q;
    busy_d     = busy_q;
    done_d     = done_q;
    fault_d    = fault_q;
    code_d     = code_q;
    fidx_d     = fidx_q;
    go_fault   = 1'b0;
    go_lock    = 1'b0;
    new_code   = FaultNone;
    new_idx    = 3'd0;

    if (rd_req_q && !ack) wait_d = wait_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (cfg_start) begin
          state_d   = StRdCnt;
          rd_req_d  = 1'b1;
          rd_addr_d = tbl_addr(META_BASE, CNT_OFS, 3'd0);
          wait_d    = '0;
          idx_d     = 3'd0;
          busy_d    = 1'b1;
        end
      end
      StRdCnt, StRdMin, StRdMax: begin
        if (!rd_req_q) begin
          // Entry cycle after a completed read keeps rd_req low for one cycle.
          rd_req_d  = 1'b1;
          rd_addr_d = (state_q == StRdMax) ? tbl_addr(META_BASE, MAX_OFS, idx_q)
                                           : tbl_addr(META_BASE, MIN_OFS, idx_q);
          wait_d    = '0;
        end else if (ack) begin
          rd_req_d = 1'b0;
          if (state_q == StRdCnt) begin
            cnt_d = rd.rd_data[3:0];
            if (rd.rd_data[3:0] > 4'(N_REGIONS)) begin
              go_fault = 1'b1;
              new_code = FaultCount;
            end else if (rd.rd_data[3:0] == 4'd0) begin
              go_lock = 1'b1;
            end else begin
              idx_d   = 3'd0;
              state_d = StRdMin;
            end
          end else if (state_q == StRdMin) begin
            if (rd.rd_data[0]) begin
              go_fault = 1'b1;
              new_code = FaultAlign;
              new_idx  = idx_q;
            end else begin
              min_sh_d[idx_q] = rd.rd_data;
              state_d         = StRdMax;
            end
          end else begin
            if (rd.rd_data[0]) begin
              go_fault = 1'b1;
              new_code = FaultAlign;
              new_idx  = idx_q;
            end else if (min_sh_q[idx_q] > rd.rd_data) begin
              go_fault = 1'b1;
              new_code = FaultBounds;
              new_idx  = idx_q;
            end else begin
              max_sh_d[idx_q] = rd.rd_data;
              if ({1'b0, idx_q} == cnt_q - 4'd1) begin
                state_d = StChk;
                ci_d    = 3'd0;
                cj_d    = 3'd1;
              end else begin
                idx_d   = idx_q + 3'd1;
                state_d = StRdMin;
              end
            end
          end
        end else if (wait_q == WaitW'(TIMEOUT - 1)) begin
          go_fault = 1'b1;
          new_code = FaultTimeout;
          new_idx  = idx_q;
        end
      end
      StChk: begin
        // cj beyond count only happens for a single-region table: nothing to compare.
        if ({1'b0, cj_q} >= cnt_q) begin
          go_lock = 1'b1;
        end else if (pair_overlap) begin
          go_fault = 1'b1;
          new_code = FaultOverlap;
          new_idx  = ci_q;
        end else if ({1'b0, cj_q} == cnt_q - 4'd1) begin
          if ({1'b0, ci_q} == cnt_q - 4'd2) begin
            go_lock = 1'b1;
          end else begin
            ci_d = ci_q + 3'd1;
            cj_d = ci_q + 3'd2;
          end
        end else begin
          cj_d = cj_q + 3'd1;
        end
      end
      default: ;
    endcase

    if (go_fault) begin
      state_d  = StFault;
      rd_req_d = 1'b0;
      busy_d   = 1'b0;
      fault_d  = 1'b1;
      code_d   = new_code;
      fidx_d   = new_idx;
    end else if (go_lock) begin
      state_d = StLocked;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      for (int k = 0; k < N_REGIONS; k++) begin
        if (4'(k) < cnt_d) begin
          en_d[k]             = 1'b1;
          min_flat_d[16*k+:16] = min_sh_q[k];
          max_flat_d[16*k+:16] = max_sh_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state_q    <= StIdle;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 16'd0;
      wait_q     <= '0;
      cnt_q      <= 4'd0;
      idx_q      <= 3'd0;
      ci_q       <= 3'd0;
      cj_q       <= 3'd0;
      for (int k = 0; k < N_REGIONS_MAX; k++) begin
        min_sh_q[k] <= 16'd0;
        max_sh_q[k] <= 16'd0;
      end
      min_flat_q <= {N_REGIONS{16'hFFFF}};
      max_flat_q <= '0;
      en_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      code_q     <= FaultNone;
      fidx_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      wait_q     <= wait_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ci_q       <= ci_d;
      cj_q       <= cj_d;
      min_sh_q   <= min_sh_d;
      max_sh_q   <= max_sh_d;
      min_flat_q <= min_flat_d;
      max_flat_q <= max_flat_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      code_q     <= code_d;
      fidx_q     <= fidx_d;
    end
  end

  assign rd.rd_req    = rd_req_q;
  assign rd.rd_addr   = rd_addr_q;
  assign ucc_min_flat = min_flat_q;
  assign ucc_max_flat = max_flat_q;
  assign region_en    = en_q;
  assign cfg_busy     = busy_q;
  assign cfg_done     = done_q;
  assign cfg_fault    = fault_q;
  assign fault_code   = code_q;
  assign fault_idx    = fidx_q;

endmodule

// File: tb/tb_ucca_cfg_ctrl.sv
// Directed bench for ucca_cfg_ctrl: table-driven table fetches plus lock/reset/timeout sequences.
module tb_ucca_cfg_ctrl;

  logic         clk;
  logic         system_reset;
  logic         cfg_start;
  logic [127:0] ucc_min_flat;
  logic [127:0] ucc_max_flat;
  logic [7:0]   region_en;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_fault;
  logic [2:0]   fault_code;
  logic [2:0]   fault_idx;

  ucca_cfg_ctrl_if bus ();

  ucca_cfg_ctrl #(
    .N_REGIONS (8),
    .META_BASE (16'h0140),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .cfg_start    (cfg_start),
    .rd           (bus),
    .ucc_min_flat (ucc_min_flat),
    .ucc_max_flat (ucc_max_flat),
    .region_en    (region_en),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_fault    (cfg_fault),
    .fault_code   (fault_code),
    .fault_idx    (fault_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // META memory model, written by the main process only.
  logic [15:0] mem [32];
  int          lat;
  int          withhold;

  // Responder state, written by the responder process only.
  int          rd_num;
  int          last_hi;
  logic [15:0] addr_log [$];

  int checks;
  int errors;

  typedef struct {
    logic [15:0]      cnt_word;
    logic [7:0][15:0] mins;
    logic [7:0][15:0] maxs;
    int               lat;
    bit               exp_fault;
    logic [2:0]       exp_code;
    logic [2:0]       exp_idx;
    logic [7:0]       exp_en;
    int               exp_reads;
    logic [15:0]      exp_min0;
    logic [15:0]      exp_max0;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mkv(logic [15:0] cw, int l, bit f, logic [2:0] code,
                               logic [2:0] idx, logic [7:0] en, int reads,
                               logic [15:0] m0, logic [15:0] x0);
    vec_t v;
    v.cnt_word  = cw;
    v.mins      = '0;
    v.maxs      = '0;
    v.lat       = l;
    v.exp_fault = f;
    v.exp_code  = code;
    v.exp_idx   = idx;
    v.exp_en    = en;
    v.exp_reads = reads;
    v.exp_min0  = m0;
    v.exp_max0  = x0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Responder: acks after 'lat' cycles of rd_req, never for read number 'withhold'.
  initial begin
    bit in_req;
    int lat_cnt;
    int hi;
    int a;
    in_req      = 1'b0;
    lat_cnt     = 0;
    hi          = 0;
    rd_num      = 0;
    last_hi     = 0;
    bus.rd_ack  = 1'b0;
    bus.rd_data = 16'd0;
    forever begin
      @(negedge clk);
      bus.rd_ack = 1'b0;
      if (bus.rd_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          rd_num++;
          hi = 0;
          addr_log.push_back(bus.rd_addr);
        end
        hi++;
        last_hi = hi;
        lat_cnt++;
        if (lat_cnt >= lat && rd_num != withhold) begin
          a = int'((bus.rd_addr - 16'h0140) >> 1);
          bus.rd_ack  = 1'b1;
          bus.rd_data = (a >= 0 && a < 32) ? mem[a] : 16'h0001;
          lat_cnt     = 0;
          in_req      = 1'b0;
        end
      end else begin
        in_req  = 1'b0;
        lat_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    system_reset = 1'b1;
    cfg_start    = 1'b0;
    @(negedge clk);
    system_reset = 1'b0;
  endtask

  task automatic load(input vec_t v);
    mem[0] = v.cnt_word;
    for (int r = 0; r < 8; r++) begin
      mem[1 + 2*r] = v.mins[r];
      mem[2 + 2*r] = v.maxs[r];
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (cfg_done || cfg_fault) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_end"}, 32'(ok), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int    base;
    string p;
    p = $sformatf("v%0d", k);
    do_reset();
    load(v);
    lat      = v.lat;
    withhold = -1;
    base     = rd_num;
    pulse_start();
    wait_end(p);
    idle(5);
    chk({p, "_fault"}, 32'(cfg_fault), 32'(v.exp_fault));
    chk({p, "_done"},  32'(cfg_done),  32'(!v.exp_fault));
    chk({p, "_busy"},  32'(cfg_busy),  32'd0);
    chk({p, "_code"},  32'(fault_code), 32'(v.exp_code));
    chk({p, "_idx"},   32'(fault_idx),  32'(v.exp_idx));
    chk({p, "_en"},    32'(region_en),  32'(v.exp_en));
    chk({p, "_reads"}, 32'(rd_num - base), 32'(v.exp_reads));
    chk({p, "_min0"},  32'(ucc_min_flat[15:0]), 32'(v.exp_min0));
    chk({p, "_max0"},  32'(ucc_max_flat[15:0]), 32'(v.exp_max0));
  endtask

  initial begin
    int    base;
    bit    seen;
    logic [15:0] exp_addr [5];

    system_reset = 1'b1;
    cfg_start    = 1'b0;
    lat          = 1;
    withhold     = -1;
    checks       = 0;
    errors       = 0;
    for (int m = 0; m < 32; m++) mem[m] = 16'd0;

    //                 cnt     lat fault code idx en     reads min0      max0
    vecs[0]  = mkv(16'h0002, 1, 0, 3'd0, 3'd0, 8'h03, 5,  16'hE000, 16'hE0FE);
    vecs[0].mins[0] = 16'hE000; vecs[0].maxs[0] = 16'hE0FE;
    vecs[0].mins[1] = 16'hE200; vecs[0].maxs[1] = 16'hE2FE;
    vecs[1]  = mkv(16'h0009, 1, 1, 3'd1, 3'd0, 8'h00, 1,  16'hFFFF, 16'h0000);
    vecs[2]  = mkv(16'h0002, 1, 1, 3'd4, 3'd0, 8'h00, 5,  16'hFFFF, 16'h0000);
    vecs[2].mins[0] = 16'hE000; vecs[2].maxs[0] = 16'hE100;
    vecs[2].mins[1] = 16'hE100; vecs[2].maxs[1] = 16'hE200;
    vecs[3]  = vecs[2];
    vecs[3].mins[0] = 16'hE101; vecs[3].exp_code = 3'd2; vecs[3].exp_reads = 2;
    vecs[4]  = mkv(16'h0001, 1, 1, 3'd3, 3'd0, 8'h00, 3,  16'hFFFF, 16'h0000);
    vecs[4].mins[0] = 16'hF000; vecs[4].maxs[0] = 16'hE000;
    vecs[5]  = mkv(16'h0000, 1, 0, 3'd0, 3'd0, 8'h00, 1,  16'hFFFF, 16'h0000);
    vecs[6]  = mkv(16'h0003, 2, 1, 3'd4, 3'd0, 8'h00, 7,  16'hFFFF, 16'h0000);
    vecs[6].mins[0] = 16'h1000; vecs[6].maxs[0] = 16'h10FE;
    vecs[6].mins[1] = 16'h2000; vecs[6].maxs[1] = 16'h20FE;
    vecs[6].mins[2] = 16'h10FE; vecs[6].maxs[2] = 16'h1100;
    vecs[7]  = mkv(16'h0003, 1, 1, 3'd4, 3'd1, 8'h00, 7,  16'hFFFF, 16'h0000);
    vecs[7].mins[0] = 16'h3000; vecs[7].maxs[0] = 16'h30FE;
    vecs[7].mins[1] = 16'h1000; vecs[7].maxs[1] = 16'h1FFE;
    vecs[7].mins[2] = 16'h1FFE; vecs[7].maxs[2] = 16'h2000;
    vecs[8]  = mkv(16'h0008, 3, 0, 3'd0, 3'd0, 8'hFF, 17, 16'h1000, 16'h10FE);
    for (int r = 0; r < 8; r++) begin
      vecs[8].mins[r] = 16'h1000 * 16'(r + 1);
      vecs[8].maxs[r] = 16'h1000 * 16'(r + 1) + 16'h00FE;
    end
    vecs[9]  = vecs[0];
    vecs[9].cnt_word = 16'h0FF2;
    vecs[10] = mkv(16'h0001, 1, 0, 3'd0, 3'd0, 8'h01, 3,  16'h4000, 16'h4000);
    vecs[10].mins[0] = 16'h4000; vecs[10].maxs[0] = 16'h4000;
    vecs[11] = mkv(16'h0001, 1, 1, 3'd2, 3'd0, 8'h00, 3,  16'hFFFF, 16'h0000);
    vecs[11].mins[0] = 16'h4000; vecs[11].maxs[0] = 16'h4001;
    vecs[12] = mkv(16'h0002, 1, 1, 3'd3, 3'd1, 8'h00, 5,  16'hFFFF, 16'h0000);
    vecs[12].mins[0] = 16'h1000; vecs[12].maxs[0] = 16'h10FE;
    vecs[12].mins[1] = 16'h9000; vecs[12].maxs[1] = 16'h8000;

    // Reset state
    do_reset();
    @(posedge clk); #1;
    chk("rst_req",  32'(bus.rd_req), 32'd0);
    chk("rst_addr", 32'(bus.rd_addr), 32'd0);
    chk("rst_min",  32'(ucc_min_flat == {8{16'hFFFF}}), 32'd1);
    chk("rst_max",  32'(ucc_max_flat == 128'd0), 32'd1);
    chk("rst_stat", {24'd0, region_en}, 32'd0);
    chk("rst_flags", {26'd0, cfg_busy, cfg_done, cfg_fault, fault_code}, 32'd0);

    for (int k = 0; k < 13; k++) run_vec(vecs[k], k);

    // First request timing and full address sequence
    do_reset();
    load(vecs[0]);
    lat      = 1;
    withhold = -1;
    base     = addr_log.size();
    @(negedge clk);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    chk("start_req",  32'(bus.rd_req), 32'd1);
    chk("start_addr", 32'(bus.rd_addr), 32'h0140);
    chk("start_busy", 32'(cfg_busy), 32'd1);
    @(negedge clk);
    cfg_start = 1'b0;
    wait_end("seq_addr");
    exp_addr = '{16'h0140, 16'h0142, 16'h0144, 16'h0146, 16'h0148};
    chk("seq_nreads", 32'(addr_log.size() - base), 32'd5);
    for (int a = 0; a < 5; a++) begin
      if (base + a < addr_log.size())
        chk($sformatf("seq_addr%0d", a), 32'(addr_log[base + a]), 32'(exp_addr[a]));
    end

    // Locked configuration ignores a new start and a new table
    base = rd_num;
    mem[0] = 16'h0001;
    mem[1] = 16'h7000;
    mem[2] = 16'h70FE;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rd_req) seen = 1'b1;
    end
    chk("lock_noreq", 32'(seen), 32'd0);
    chk("lock_reads", 32'(rd_num - base), 32'd0);
    chk("lock_en",    32'(region_en), 32'h03);
    chk("lock_min",   32'(ucc_min_flat[31:0]), 32'hE200E000);
    chk("lock_max",   32'(ucc_max_flat[31:0]), 32'hE2FEE0FE);
    chk("lock_done",  {30'd0, cfg_done, cfg_busy}, 32'd2);

    // Ack withheld on the second read -> timeout after 16 request cycles
    do_reset();
    load(vecs[0]);
    lat      = 1;
    withhold = rd_num + 2;
    pulse_start();
    wait_end("tmo");
    idle(2);
    chk("tmo_fault", 32'(cfg_fault), 32'd1);
    chk("tmo_code",  32'(fault_code), 32'd5);
    chk("tmo_idx",   32'(fault_idx), 32'd0);
    chk("tmo_hi",    32'(last_hi), 32'd16);
    chk("tmo_req",   32'(bus.rd_req), 32'd0);
    chk("tmo_en",    32'(region_en), 32'd0);
    withhold = -1;

    // Reset during RD_MAX of region 1, with cfg_start in the same cycle
    do_reset();
    load(vecs[0]);
    lat  = 3;
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.rd_req && bus.rd_addr == 16'h0148) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("mid_reach", 32'(seen), 32'd1);
    system_reset = 1'b1;
    cfg_start    = 1'b1;
    @(posedge clk); #1;
    chk("mid_req",   32'(bus.rd_req), 32'd0);
    chk("mid_addr",  32'(bus.rd_addr), 32'd0);
    chk("mid_min",   32'(ucc_min_flat == {8{16'hFFFF}}), 32'd1);
    chk("mid_flags", {21'd0, region_en, cfg_busy, cfg_done, cfg_fault}, 32'd0);
    @(negedge clk);
    system_reset = 1'b0;
    cfg_start    = 1'b0;
    @(posedge clk); #1;
    chk("mid_idle",  {30'd0, bus.rd_req, cfg_busy}, 32'd0);
    base = rd_num;
    pulse_start();
    wait_end("mid_rerun");
    idle(2);
    chk("mid_done",  32'(cfg_done), 32'd1);
    chk("mid_en",    32'(region_en), 32'h03);
    chk("mid_reads", 32'(rd_num - base), 32'd5);
    chk("mid_min0",  32'(ucc_min_flat[15:0]), 32'hE000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
